canvas_framebuffer: RTL and testbench
=====================================

Name: canvas_framebuffer

Overview:
- 1-bit-per-pixel drawing canvas feeding the VGA display controller's DATA_OUT word.
- Holds a 640x480 monochrome bitmap as 32-bit words: 20 words per row, 9600 words total.
- Mouse draw/erase requests stamp a square brush into the bitmap by read-modify-write on one RAM port.
- A second RAM port streams the word under the current DrawX/DrawY to the display every CLK.

Parameters:
- H_RES, 640: canvas width in pixels; must be a multiple of 32.
- V_RES, 480: canvas height in pixels.
- BRUSH_SIZE, 4: brush edge in pixels; legal range 1..32.
- WORDS_PER_ROW, H_RES/32: derived, not overridable.
- DEPTH, WORDS_PER_ROW*V_RES: derived, not overridable.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- MOUSE_X  in  10  stamp origin column.
- MOUSE_Y  in  10  stamp origin row.
- MOUSE_STATUS  in  2  1 = draw (set bits), 2 = erase (clear bits), 0 or 3 = no request.
- CLEAR  in  1  one-cycle request to zero the whole canvas.
- DrawX  in  10  display scan column.
- DrawY  in  10  display scan row.
- DATA_OUT  out  32  canvas word containing (DrawX, DrawY); bit DrawX[4:0] is the pixel.
- BUSY  out  1  engine is executing a stamp or clear.
- DONE  out  1  one-cycle pulse when a stamp or clear completes.

Behaviour:
- Addressing:
  - word = y*WORDS_PER_ROW + x[9:5]; bit = x[4:0].
  - The RAM is dual-port. Port A (engine) does read then write. Port B (display) is read-only.
  - Both ports have 1-cycle registered read latency.
  - Same-address port-A write and port-B read in one cycle: port B returns the old data.
  - RAM is zero at configuration. RESET does not alter RAM contents.
- Display port:
  - Each CLK, DATA_OUT <= word(DrawX, DrawY), so latency is 1 CLK.
  - If DrawX >= H_RES or DrawY >= V_RES, DATA_OUT <= 0.
- Reset:
  - FSM goes to IDLE; BUSY = 0, DONE = 0, DATA_OUT = 0.
  - Reset mid-stamp or mid-clear aborts the operation with no further writes; words already written stay written.
- FSM states: IDLE, CLR, RD, WR.
- IDLE:
  - CLEAR = 1: go to CLR; CLEAR has priority over a simultaneous stamp request.
  - Otherwise, MOUSE_STATUS in {1, 2} with MOUSE_X < H_RES and MOUSE_Y < V_RES:
    - Latch X0, Y0 and the mode; go to RD.
    - Columns covered: X0 .. min(X0+BRUSH_SIZE-1, H_RES-1).
    - Rows covered: Y0 .. min(Y0+BRUSH_SIZE-1, V_RES-1).
  - An off-canvas origin or MOUSE_STATUS of 0 or 3 is ignored.
  - Inputs are ignored while not in IDLE. A level held on MOUSE_STATUS re-triggers as soon as IDLE is re-entered.
- CLR:
  - Writes 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), then DONE and back to IDLE.
- RD / WR (stamp loop):
  - Order: row-major over rows. Within a row, over the 1 or 2 words the column span touches (BRUSH_SIZE <= 32).
  - RD: issue the port-A read.
  - WR: data returns; write data | mask (draw) or data & ~mask (erase).
    - mask has ones for the covered columns that fall inside that word.
  - Next word or row goes to RD. After the last write, go to IDLE.
  - Total stamp = 2 x (words touched) cycles.
- BUSY: 1 in CLR, RD and WR; 0 in IDLE.
- DONE: pulses for exactly one cycle, in the cycle IDLE is entered from the final CLR or WR cycle.

Test Plan:
- Reset, pulse CLEAR -> BUSY high 9600 cycles, DONE pulse once; scanning every DrawX/DrawY gives DATA_OUT = 0.
- Draw at (100,200), BRUSH_SIZE 4 -> words 4003, 4023, 4043, 4063 become 0x000000F0; 8 BUSY cycles; DrawX = 96, DrawY = 201 gives DATA_OUT = 0x000000F0 one CLK later.
- Draw at (30,10) -> per row 10..13: word y*20 gets 0xC0000000 and word y*20+1 gets 0x00000003; 16 BUSY cycles.
- After the (100,200) draw, erase at (100,201) -> words 4023, 4043, 4063 become 0; word 4003 stays 0x000000F0.
- Draw at (638,478) -> words 9579 and 9599 become 0xC0000000; 4 BUSY cycles. Draw at (700,10) -> ignored, no BUSY, no DONE.
- Assert RESET during a stamp's second row -> next cycle BUSY = 0, first row written, rest untouched, no DONE; MOUSE_STATUS = 3 -> no response.

Source files
------------

// File: rtl/canvas_framebuffer.sv
// canvas_framebuffer
//   1-bit-per-pixel monochrome canvas (H_RES x V_RES) stored as 32-bit words.
//   Port A runs the drawing engine, which stamps a square brush by
//   read-modify-write or clears the whole canvas. Port B is read-only and
//   streams the word under the display scan position to DATA_OUT.
//
// Ports
//   CLK, RESET          rising-edge clock, synchronous active-high reset
//   MOUSE_X/Y           stamp origin (column/row)
//   MOUSE_STATUS        1 = draw, 2 = erase, 0/3 = no request
//   CLEAR               one-cycle request to zero the canvas (wins over a stamp)
//   DrawX/DrawY         display scan position
//   DATA_OUT            word holding (DrawX, DrawY), 1-cycle latency, 0 off-canvas
//   BUSY                engine is clearing or stamping
//   DONE                one-cycle pulse when a clear or stamp completes
module canvas_framebuffer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BRUSH_SIZE = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [9:0]  MOUSE_X,
  input  logic [9:0]  MOUSE_Y,
  input  logic [1:0]  MOUSE_STATUS,
  input  logic        CLEAR,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [31:0] DATA_OUT,
  output logic        BUSY,
  output logic        DONE
);

  localparam int WORDS_PER_ROW = H_RES / 32;
  localparam int DEPTH         = WORDS_PER_ROW * V_RES;
  localparam int ADDR_W        = $clog2(DEPTH);
  localparam logic [31:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, CLR, RD, WR} state_t;

  state_t              state_q, state_d;
  logic [9:0]          x0_q, x0_d;
  logic [9:0]          y0_q, y0_d;
  logic [9:0]          row_q, row_d;
  logic [4:0]          wcol_q, wcol_d;
  logic                erase_q, erase_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                done_q, done_d;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         rd_a_q;
  logic [31:0]         data_out_q;

  logic [10:0]         x_sum, y_sum;
  logic [9:0]          x_end, y_end;
  logic [4:0]          lo_bit, hi_bit;
  logic [31:0]         mask;

  logic [ADDR_W-1:0]   addr_a, addr_b;
  logic                we_a;
  logic [31:0]         wdata_a;
  logic                b_valid;
  logic                req_valid;

  // Brush span clipped to the canvas, and the mask of covered columns
  // falling inside the word currently addressed by wcol_q.
  always_comb begin
    x_sum  = {1'b0, x0_q} + 11'(BRUSH_SIZE - 1);
    y_sum  = {1'b0, y0_q} + 11'(BRUSH_SIZE - 1);
    x_end  = (x_sum > 11'(H_RES - 1)) ? 10'(H_RES - 1) : x_sum[9:0];
    y_end  = (y_sum > 11'(V_RES - 1)) ? 10'(V_RES - 1) : y_sum[9:0];
    lo_bit = (wcol_q == x0_q[9:5])  ? x0_q[4:0]  : 5'd0;
    hi_bit = (wcol_q == x_end[9:5]) ? x_end[4:0] : 5'd31;
    mask   = (ALL_ONES << lo_bit) & (ALL_ONES >> (5'd31 - hi_bit));
  end

  always_comb begin
    addr_b  = ADDR_W'({10'd0, DrawY} * 20'(WORDS_PER_ROW) + {15'd0, DrawX[9:5]});
    b_valid = ({1'b0, DrawX} < 11'(H_RES)) && ({1'b0, DrawY} < 11'(V_RES));
    req_valid = ((MOUSE_STATUS == 2'd1) || (MOUSE_STATUS == 2'd2)) &&
                ({1'b0, MOUSE_X} < 11'(H_RES)) && ({1'b0, MOUSE_Y} < 11'(V_RES));
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    row_d      = row_q;
    wcol_d     = wcol_q;
    erase_d    = erase_q;
    clr_addr_d = clr_addr_q;
    done_d     = 1'b0;
    we_a       = 1'b0;
    wdata_a    = '0;
    addr_a     = ADDR_W'({10'd0, row_q} * 20'(WORDS_PER_ROW) + {15'd0, wcol_q});

    case (state_q)
      IDLE: begin
        if (CLEAR) begin
          clr_addr_d = '0;
          state_d    = CLR;
        end else if (req_valid) begin
          x0_d    = MOUSE_X;
          y0_d    = MOUSE_Y;
          row_d   = MOUSE_Y;
          wcol_d  = MOUSE_X[9:5];
          erase_d = (MOUSE_STATUS == 2'd2);
          state_d = RD;
        end
      end
      CLR: begin
        addr_a  = clr_addr_q;
        we_a    = 1'b1;
        wdata_a = '0;
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      RD: begin
        state_d = WR;
      end
      WR: begin
        // Address is unchanged since RD, so rd_a_q holds this word.
        we_a    = 1'b1;
        wdata_a = erase_q ? (rd_a_q & ~mask) : (rd_a_q | mask);
        if (wcol_q != x_end[9:5]) begin
          wcol_d  = wcol_q + 5'd1;
          state_d = RD;
        end else if (row_q != y_end) begin
          row_d   = row_q + 10'd1;
          wcol_d  = x0_q[9:5];
          state_d = RD;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      row_q      <= '0;
      wcol_q     <= '0;
      erase_q    <= 1'b0;
      clr_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      row_q      <= row_d;
      wcol_q     <= wcol_d;
      erase_q    <= erase_d;
      clr_addr_q <= clr_addr_d;
      done_q     <= done_d;
    end
  end

  // Dual-port RAM. Non-blocking write means a same-address port-B read
  // sees the old word. Reset blocks the pending write so an aborted
  // stamp leaves no further changes.
  always_ff @(posedge CLK) begin
    if (we_a && !RESET) begin
      mem[addr_a] <= wdata_a;
    end
    rd_a_q <= mem[addr_a];
    if (RESET || !b_valid) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= mem[addr_b];
    end
  end

  assign DATA_OUT = data_out_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;

endmodule

// File: tb/tb_canvas_framebuffer.sv
module tb_canvas_framebuffer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [9:0]  MOUSE_X, MOUSE_Y;
  logic [1:0]  MOUSE_STATUS;
  logic        CLEAR;
  logic [9:0]  DrawX, DrawY;
  logic [31:0] DATA_OUT;
  logic        BUSY, DONE;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [9600];
  logic [31:0] sb_q [$];

  always #5 CLK = ~CLK;

  canvas_framebuffer #(.H_RES(640), .V_RES(480), .BRUSH_SIZE(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_STATUS(MOUSE_STATUS),
    .CLEAR(CLEAR), .DrawX(DrawX), .DrawY(DrawY),
    .DATA_OUT(DATA_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int x, input int y);
    if (x >= 640 || y >= 480) return 32'd0;
    return model[y * 20 + x / 32];
  endfunction

  // Pixel-level reference for a 4x4 brush clipped to the canvas.
  task automatic model_stamp(input int x0, input int y0, input bit erase);
    if (x0 >= 640 || y0 >= 480) return;
    for (int y = y0; y < y0 + 4 && y < 480; y++)
      for (int x = x0; x < x0 + 4 && x < 640; x++)
        model[y * 20 + x / 32][x % 32] = !erase;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9600; i++) model[i] = '0;
  endtask

  // Drive a scan position and queue its expected word; the previous
  // position's word is checked here, one clock after it was driven.
  task automatic probe(input int x, input int y);
    @(negedge CLK);
    if (sb_q.size() > 0) check($sformatf("dout_%0d_%0d", DrawX, DrawY), DATA_OUT, sb_q.pop_front());
    DrawX = 10'(x);
    DrawY = 10'(y);
    sb_q.push_back(exp_word(x, y));
  endtask

  task automatic flush();
    @(negedge CLK);
    while (sb_q.size() > 0) check($sformatf("dout_%0d_%0d", DrawX, DrawY), DATA_OUT, sb_q.pop_front());
  endtask

  task automatic probe_area(input int x, input int y);
    for (int dy = -1; dy <= 4; dy++)
      for (int dx = -32; dx <= 32; dx += 32)
        if (x + dx >= 0 && y + dy >= 0 && x + dx < 1024 && y + dy < 1024)
          probe(x + dx, y + dy);
    flush();
  endtask

  task automatic request(input int x, input int y, input logic [1:0] st, input logic clr);
    @(negedge CLK);
    MOUSE_X      = 10'(x);
    MOUSE_Y      = 10'(y);
    MOUSE_STATUS = st;
    CLEAR        = clr;
  endtask

  // Count BUSY cycles and DONE pulses until the engine has been idle
  // for three samples (bounded by a cycle budget).
  task automatic run_op(input string tag, input int exp_busy, input int exp_done);
    int busy = 0;
    int dn = 0;
    int idle_run = 0;
    for (int i = 0; i < 12000 && idle_run < 3; i++) begin
      @(negedge CLK);
      MOUSE_STATUS = 2'd0;
      CLEAR        = 1'b0;
      if (BUSY) begin
        busy++;
        idle_run = 0;
      end else begin
        idle_run++;
      end
      if (DONE) dn++;
    end
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check({tag, "_done"}, 32'(dn), 32'(exp_done));
  endtask

  initial begin
    RESET = 1'b1; MOUSE_X = '0; MOUSE_Y = '0; MOUSE_STATUS = '0;
    CLEAR = 1'b0; DrawX = '0; DrawY = '0;
    model_clear();
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_dout", DATA_OUT, 32'd0);
    RESET = 1'b0;

    // Clear with a simultaneous draw request: clear must win.
    request(100, 100, 2'd1, 1'b1);
    run_op("clear", 9600, 1);
    model_clear();
    for (int y = 0; y < 480; y++)
      for (int w = 0; w < 20; w++)
        probe(w * 32 + (y % 32), y);
    probe(640, 0);
    probe(0, 480);
    probe(1023, 1023);
    flush();

    request(100, 200, 2'd1, 1'b0);
    model_stamp(100, 200, 1'b0);
    run_op("draw_100_200", 8, 1);
    probe(96, 201);
    flush();
    check("w4003", model[4003], 32'h000000F0);
    probe_area(100, 200);

    request(30, 10, 2'd1, 1'b0);
    model_stamp(30, 10, 1'b0);
    run_op("draw_30_10", 16, 1);
    probe_area(30, 10);
    probe_area(0, 10);

    request(100, 201, 2'd2, 1'b0);
    model_stamp(100, 201, 1'b1);
    run_op("erase_100_201", 8, 1);
    probe_area(100, 200);

    request(638, 478, 2'd1, 1'b0);
    model_stamp(638, 478, 1'b0);
    run_op("draw_638_478", 4, 1);
    probe_area(638, 477);

    request(700, 10, 2'd1, 1'b0);
    run_op("off_canvas", 0, 0);
    probe_area(608, 10);

    request(200, 50, 2'd3, 1'b0);
    run_op("status3", 0, 0);
    probe_area(200, 50);

    // Reset during the write of the second row's first word.
    request(30, 100, 2'd1, 1'b0);
    repeat (6) begin
      @(negedge CLK);
      MOUSE_STATUS = 2'd0;
    end
    check("mid_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_dout", DATA_OUT, 32'd0);
    RESET = 1'b0;
    for (int x = 30; x < 34; x++) model[100 * 20 + x / 32][x % 32] = 1'b1;
    run_op("after_abort", 0, 0);
    probe_area(30, 100);

    request(0, 0, 2'd0, 1'b1);
    run_op("clear2", 9600, 1);
    model_clear();
    probe_area(100, 200);
    probe_area(638, 477);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
